// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined 64-bit CPU: word width,
// ALU operation codes and forwarding-mux selects.
package cpu_pkg;

    localparam int DWIDTH = 64;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'b000,
        ALU_ADD    = 3'b010,
        ALU_SUB    = 3'b011,
        ALU_AND    = 3'b100,
        ALU_OR     = 3'b101,
        ALU_XOR    = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/data_ex_alu64.sv
// Combinational 64-bit ALU with raw NZVC flags. Subtraction is A + ~B + 1,
// so carry=1 means "no borrow".
module alu64
    import cpu_pkg::*;
(
    input  logic [DWIDTH-1:0] A,
    input  logic [DWIDTH-1:0] B,
    input  logic [2:0]        ALUop,
    output logic [DWIDTH-1:0] result,
    output logic              N,
    output logic              Z,
    output logic              V,
    output logic              C
);

    logic [DWIDTH-1:0] b_eff;
    logic [DWIDTH:0]   sum;
    logic              is_arith;

    always_comb begin
        is_arith = (ALUop == ALU_ADD) || (ALUop == ALU_SUB);
        b_eff    = (ALUop == ALU_SUB) ? ~B : B;
        sum      = {1'b0, A} + {1'b0, b_eff} + {{DWIDTH{1'b0}}, (ALUop == ALU_SUB)};

        case (ALUop)
            ALU_PASS_B: result = B;
            ALU_ADD,
            ALU_SUB:    result = sum[DWIDTH-1:0];
            ALU_AND:    result = A & B;
            ALU_OR:     result = A | B;
            ALU_XOR:    result = A ^ B;
            default:    result = '0;
        endcase

        N = result[DWIDTH-1];
        Z = (result == '0);
        C = is_arith && sum[DWIDTH];
        // Overflow: operands share a sign that the sum does not
        V = is_arith && (A[DWIDTH-1] == b_eff[DWIDTH-1])
                     && (sum[DWIDTH-1] != A[DWIDTH-1]);
    end

endmodule

// File: rtl/data_ex.sv
// Execute stage: operand forwarding, immediate select, ALU, BL return-address
// override, and the NZVC flag register read by ID-stage conditional branches.
module data_ex
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] ReadData1,
    input  logic [DWIDTH-1:0] ReadData2,
    input  logic [DWIDTH-1:0] PC,
    input  logic [DWIDTH-1:0] ALU_or_DT,
    input  logic [DWIDTH-1:0] alu_result_mem,
    input  logic [DWIDTH-1:0] alu_result_wb,
    input  logic [DWIDTH-1:0] BLT,
    input  logic [2:0]        ALUop,
    input  logic              ALUsrc,
    input  logic              update,
    input  logic              cbz_id,
    input  logic              BLsignal,
    input  logic [1:0]        forwardA,
    input  logic [1:0]        forwardB,
    output logic [DWIDTH-1:0] alu_result,
    output logic              negative,
    output logic              zero,
    output logic              overflow,
    output logic              carry_out
);

    logic [DWIDTH-1:0] op_a;
    logic [DWIDTH-1:0] fwd_b;
    logic [DWIDTH-1:0] op_b;
    logic [DWIDTH-1:0] alu_out;
    logic              raw_n, raw_z, raw_v, raw_c;
    logic [3:0]        flags;
    logic              pc_unused;

    assign pc_unused = ^PC;

    always_comb begin
        case (forwardA)
            FWD_MEM: op_a = alu_result_mem;
            FWD_WB:  op_a = alu_result_wb;
            default: op_a = ReadData1;
        endcase

        case (forwardB)
            FWD_MEM: fwd_b = alu_result_mem;
            FWD_WB:  fwd_b = alu_result_wb;
            default: fwd_b = ReadData2;
        endcase

        op_b = ALUsrc ? ALU_or_DT : fwd_b;
    end

    alu64 u_alu (
        .A      (op_a),
        .B      (op_b),
        .ALUop  (ALUop),
        .result (alu_out),
        .N      (raw_n),
        .Z      (raw_z),
        .V      (raw_v),
        .C      (raw_c)
    );

    assign alu_result = BLsignal ? BLT : alu_out;

    // Stored as {N, Z, V, C}
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            flags <= 4'b0000;
        else if (update)
            flags <= {raw_n, raw_z, raw_v, raw_c};
    end

    // Bypass fresh flags for a flag-setter; CBZ only needs the live zero test
    always_comb begin
        if (update)
            {negative, zero, overflow, carry_out} = {raw_n, raw_z, raw_v, raw_c};
        else if (cbz_id)
            {negative, zero, overflow, carry_out} = {flags[3], raw_z, flags[1], flags[0]};
        else
            {negative, zero, overflow, carry_out} = flags;
    end

endmodule

// File: tb/tb_data_ex.sv
// Directed self-checking bench for data_ex; expected values are hand-computed.
module tb_data_ex;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] ReadData1, ReadData2, PC, ALU_or_DT, alu_result_mem, alu_result_wb, BLT;
    logic [2:0]  ALUop;
    logic        ALUsrc, update, cbz_id, BLsignal;
    logic [1:0]  forwardA, forwardB;
    logic [63:0] alu_result;
    logic        negative, zero, overflow, carry_out;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    data_ex dut (
        .clk(clk), .reset(reset),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .PC(PC), .ALU_or_DT(ALU_or_DT),
        .alu_result_mem(alu_result_mem), .alu_result_wb(alu_result_wb), .BLT(BLT),
        .ALUop(ALUop), .ALUsrc(ALUsrc), .update(update), .cbz_id(cbz_id),
        .BLsignal(BLsignal), .forwardA(forwardA), .forwardB(forwardB),
        .alu_result(alu_result), .negative(negative), .zero(zero),
        .overflow(overflow), .carry_out(carry_out)
    );

    task automatic set_defaults();
        ReadData1 = 64'd0; ReadData2 = 64'd0; PC = 64'h400; ALU_or_DT = 64'd0;
        alu_result_mem = 64'd0; alu_result_wb = 64'd0; BLT = 64'd0;
        ALUop = 3'b000; ALUsrc = 1'b0; update = 1'b0; cbz_id = 1'b0;
        BLsignal = 1'b0; forwardA = 2'b00; forwardB = 2'b00;
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_defaults();
        reset = 1'b0;
        ReadData1 = 64'd2; ReadData2 = 64'd3; ALUop = 3'b010;
        #1;
        total++;
        if ({negative, zero, overflow, carry_out} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {negative, zero, overflow, carry_out});
        else passed++;
        total++;
        if (alu_result !== 64'd5)
            $display("FAIL reset_alu: got %h want 5", alu_result);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_forward_a();
        logic [1:0]  sel [4]  = '{2'b00, 2'b10, 2'b01, 2'b11};
        logic [63:0] exp [4]  = '{64'd6, 64'd10, 64'd8, 64'd6};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_defaults();
            ReadData1 = 64'd5; alu_result_mem = 64'd9; alu_result_wb = 64'd7;
            ALUop = 3'b010; ALUsrc = 1'b1; ALU_or_DT = 64'd1; forwardA = sel[i];
            #1;
            total++;
            if (alu_result !== exp[i])
                $display("FAIL fwd_a_%b: got %0d want %0d", sel[i], alu_result, exp[i]);
            else passed++;
        end
    endtask

    task automatic test_forward_b();
        logic [1:0]  sel [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
        logic [63:0] exp [4] = '{64'd11, 64'd22, 64'd33, 64'd11};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_defaults();
            ReadData2 = 64'd11; alu_result_mem = 64'd22; alu_result_wb = 64'd33;
            ALUop = 3'b000; forwardB = sel[i];
            #1;
            total++;
            if (alu_result !== exp[i])
                $display("FAIL fwd_b_%b: got %0d want %0d", sel[i], alu_result, exp[i]);
            else passed++;
        end
        // Immediate is never forwarded
        @(negedge clk);
        set_defaults();
        ReadData2 = 64'd11; alu_result_mem = 64'd22; ALU_or_DT = 64'd44;
        forwardB = 2'b10; ALUsrc = 1'b1;
        #1;
        total++;
        if (alu_result !== 64'd44)
            $display("FAIL fwd_b_imm: got %0d want 44", alu_result);
        else passed++;
    endtask

    task automatic test_logic_ops();
        logic [2:0]  ops [5] = '{3'b100, 3'b101, 3'b110, 3'b001, 3'b111};
        logic [63:0] exp [5] = '{64'h0000_0000_0000_0008, 64'hFFFF_0000_0000_00FE,
                                 64'hFFFF_0000_0000_00F6, 64'd0, 64'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_defaults();
            ReadData1 = 64'hFFFF_0000_0000_000C; ReadData2 = 64'h0000_0000_0000_00FA;
            ALUop = ops[i];
            #1;
            total++;
            if (alu_result !== exp[i])
                $display("FAIL logic_op_%b: got %h want %h", ops[i], alu_result, exp[i]);
            else passed++;
        end
    endtask

    task automatic test_subs();
        @(negedge clk);
        set_defaults();
        ReadData1 = 64'd3; ReadData2 = 64'd5; ALUop = 3'b011; update = 1'b1;
        #1;
        total++;
        if (alu_result !== 64'hFFFF_FFFF_FFFF_FFFE)
            $display("FAIL subs_result: got %h want fffffffffffffffe", alu_result);
        else passed++;
        total++;
        if ({negative, zero, overflow, carry_out} !== 4'b1000)
            $display("FAIL subs_bypass_flags: got %b want 1000", {negative, zero, overflow, carry_out});
        else passed++;
        @(negedge clk);
        set_defaults();
        #1;
        total++;
        if ({negative, zero, overflow, carry_out} !== 4'b1000)
            $display("FAIL subs_reg_flags: got %b want 1000", {negative, zero, overflow, carry_out});
        else passed++;
    endtask

    task automatic test_overflow();
        @(negedge clk);
        set_defaults();
        ReadData1 = 64'h7FFF_FFFF_FFFF_FFFF; ReadData2 = 64'd1; ALUop = 3'b010; update = 1'b1;
        #1;
        total++;
        if (alu_result !== 64'h8000_0000_0000_0000 || {negative, zero, overflow, carry_out} !== 4'b1010)
            $display("FAIL adds_ovf: got %h/%b want 8000000000000000/1010",
                     alu_result, {negative, zero, overflow, carry_out});
        else passed++;
        @(negedge clk);
        ReadData1 = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        total++;
        if (alu_result !== 64'd0 || {negative, zero, overflow, carry_out} !== 4'b0101)
            $display("FAIL adds_carry: got %h/%b want 0/0101",
                     alu_result, {negative, zero, overflow, carry_out});
        else passed++;
        @(negedge clk);
        set_defaults();
        #1;
        total++;
        if ({negative, zero, overflow, carry_out} !== 4'b0101)
            $display("FAIL adds_carry_reg: got %b want 0101", {negative, zero, overflow, carry_out});
        else passed++;
    endtask

    task automatic test_cbz();
        // Store N=1 from 3-5 first
        @(negedge clk);
        set_defaults();
        ReadData1 = 64'd3; ReadData2 = 64'd5; ALUop = 3'b011; update = 1'b1;
        @(negedge clk);
        set_defaults();
        cbz_id = 1'b1; ReadData2 = 64'd0; alu_result_wb = 64'd0; forwardB = 2'b01;
        ReadData1 = 64'd77;
        #1;
        total++;
        if (alu_result !== 64'd0 || {negative, zero, overflow, carry_out} !== 4'b1100)
            $display("FAIL cbz_taken: got %h/%b want 0/1100",
                     alu_result, {negative, zero, overflow, carry_out});
        else passed++;
        @(negedge clk);
        alu_result_wb = 64'd9;
        #1;
        total++;
        if ({negative, zero, overflow, carry_out} !== 4'b1000)
            $display("FAIL cbz_not_taken: got %b want 1000", {negative, zero, overflow, carry_out});
        else passed++;
        @(negedge clk);
        set_defaults();
        #1;
        total++;
        if ({negative, zero, overflow, carry_out} !== 4'b1000)
            $display("FAIL cbz_reg_kept: got %b want 1000", {negative, zero, overflow, carry_out});
        else passed++;
    endtask

    task automatic test_update_priority();
        @(negedge clk);
        set_defaults();
        ReadData1 = 64'd4; ReadData2 = 64'd4; ALUop = 3'b011; update = 1'b1; cbz_id = 1'b1;
        #1;
        total++;
        if ({negative, zero, overflow, carry_out} !== 4'b0101)
            $display("FAIL update_over_cbz: got %b want 0101", {negative, zero, overflow, carry_out});
        else passed++;
    endtask

    task automatic test_bl();
        @(negedge clk);
        set_defaults();
        BLsignal = 1'b1; BLT = 64'h104; ALUop = 3'b010; ReadData1 = 64'd1; ReadData2 = 64'd1;
        #1;
        total++;
        if (alu_result !== 64'h104)
            $display("FAIL bl_override: got %h want 104", alu_result);
        else passed++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_defaults();
        ReadData1 = 64'h8000_0000_0000_0000; ReadData2 = 64'h8000_0000_0000_0000;
        ALUop = 3'b010; update = 1'b1;
        @(negedge clk);
        set_defaults();
        #1;
        total++;
        if ({negative, zero, overflow, carry_out} !== 4'b0111)
            $display("FAIL pre_reset_flags: got %b want 0111", {negative, zero, overflow, carry_out});
        else passed++;
        #2;
        reset = 1'b0;
        ReadData1 = 64'd10; ReadData2 = 64'd3; ALUop = 3'b011;
        #1;
        total++;
        if ({negative, zero, overflow, carry_out} !== 4'b0000)
            $display("FAIL async_reset_flags: got %b want 0000", {negative, zero, overflow, carry_out});
        else passed++;
        total++;
        if (alu_result !== 64'd7)
            $display("FAIL alu_in_reset: got %0d want 7", alu_result);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({negative, zero, overflow, carry_out} !== 4'b0000)
            $display("FAIL post_reset_hold: got %b want 0000", {negative, zero, overflow, carry_out});
        else passed++;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        #1;
        total++;
        if ({negative, zero, overflow, carry_out} !== 4'b0001)
            $display("FAIL post_reset_load: got %b want 0001", {negative, zero, overflow, carry_out});
        else passed++;
    endtask

    initial begin
        set_defaults();
        reset = 1'b1;
        test_reset();
        test_forward_a();
        test_forward_b();
        test_logic_ops();
        test_subs();
        test_overflow();
        test_cbz();
        test_update_priority();
        test_bl();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
